if_queue: RTL and testbench
===========================

# if_queue

Instruction fetch queue between the PC/instruction-ROM fetch stage and the decode stage of the pipelined MIPS core. Each cycle the fetch stage presents a `{pc, inst}` pair. The queue buffers up to DEPTH pairs and hands them to decode with a valid/ready handshake. It back-pressures the PC register with a stall, and it drops all buffered instructions on a flush caused by a branch redirect.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- AW, 2, pointer width; equals log2(DEPTH)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- if_pc_i  in  32  PC of the fetched word (pc_reg output)
- if_inst_i  in  32  fetched instruction (ROM data)
- if_valid_i  in  1  fetch word is valid; driven by the ROM chip-enable
- if_stall_o  out  1  tells pc_reg to hold the PC; high means this cycle's word is not accepted
- flush_i  in  1  branch/exception redirect; discard queue contents
- id_ready_i  in  1  decode accepts the head entry this cycle
- id_valid_o  out  1  the head entry is valid
- id_pc_o  out  32  PC of the head entry
- id_inst_o  out  32  instruction of the head entry
- count_o  out  AW+1  current occupancy, 0..DEPTH

## Operation
- Storage is DEPTH entries of 64 bits, holding {pc, inst}.
- Read pointer rd_ptr and write pointer wr_ptr are each AW bits wide and wrap modulo DEPTH.
- count is AW+1 bits wide.
- full = (count == DEPTH). empty = (count == 0).
- if_stall_o = full. This is combinational from registered state only; there is no path from id_ready_i.
- A push occurs when if_valid_i && !full && !flush_i.
  - The word is written at wr_ptr, then wr_ptr+1.
- A pop occurs when id_valid_o && id_ready_i && !flush_i.
  - rd_ptr+1.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, a push is refused even if a pop happens in the same cycle.
  - pc_reg holds the PC, so the refused word is presented again the next cycle.
  - The queue never loses a word.
- flush_i has priority over push and pop.
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - The input word presented in the flush cycle is discarded.
- When empty, id_pc_o = 0, id_inst_o = 0 (ZeroWord), and id_valid_o = 0. The exception is the bypass case described under Configuration.
- When not empty, the head outputs come from storage[rd_ptr].
- Reset has priority over flush. On reset: pointers = 0, count = 0, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, if_stall_o = 0, count_o = 0.
- Reset asserted mid-operation discards all entries. Storage contents need not be cleared.

## Timing
- Registered path: a word pushed in cycle N appears on id_*_o in cycle N+1 if the queue was empty.
- Throughput: one word per cycle in steady state while id_ready_i stays high.
- Stall assertion: if_stall_o rises in the cycle after the push that fills the queue.
- Stall release: if_stall_o falls in the cycle after the first pop from the full state.
- Flush: id_valid_o is 0 in the cycle after flush_i.
  - In the flush cycle itself, id_valid_o still reflects the pre-flush head.
  - Decode must ignore the head in the flush cycle; no pop is counted.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty, if_valid_i is high and flush_i is low, id_*_o show if_pc_i/if_inst_i combinationally and id_valid_o = 1.
  - If id_ready_i is also high, the word is consumed directly and not written. Count stays 0.
  - Otherwise the word is pushed normally.
  - Latency from an empty queue is 0 cycles.
- IFQ_BYPASS_EN undefined: no combinational path from if_* to id_*. Latency from an empty queue is 1 cycle.

## Structure
- DEPTH default, ZeroWord, InstAddrBus and InstBus widths come from the shared defines.v. No new literals appear in the RTL.
- Sub-module ifq_storage holds the DEPTH×64 register array: one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- if_queue holds the pointers, count, handshake and bypass logic.

## Test plan
- Reset: hold rst for 2 cycles with if_valid_i = 1.
  - Expect all outputs 0 and count_o = 0.
  - First push after release: pc 0x00000000, inst 0x34011100 appears on id_*_o one cycle later (0 cycles later with the bypass).
- Fill: id_ready_i = 0; push pcs 0x0, 0x4, 0x8, 0xC.
  - Expect count_o = 4 and if_stall_o = 1.
  - A 5th word at pc 0x10 is held by the stall.
  - Raise id_ready_i: pops return 0x0, 0x4, 0x8, 0xC in order, then 0x10 follows.
- Steady streaming with wrap-around: 20 consecutive words, id_ready_i = 1.
  - Expect id_pc_o to increment by 4 each cycle, count_o ≤ 1, and the pointers wrap 5 times with no gaps or duplicates.
- Full with pop: full queue, id_ready_i = 1, if_valid_i = 1.
  - The push is refused that cycle and count_o drops to 3.
  - The next cycle accepts the word and count_o returns to 4.
- Flush: with 3 entries queued, pulse flush_i alongside a valid word at pc 0x40.
  - Next cycle count_o = 0 and id_valid_o = 0.
  - pc 0x40 is never delivered.
  - The next push, pc 0x100, is the next word delivered.
- Mid-operation reset: rst during 2-entry occupancy with a simultaneous push and pop.
  - Next cycle count_o = 0, id_valid_o = 0, if_stall_o = 0.

Source files
------------

// File: rtl/if_queue_pkg.sv
// Shared widths and types for the instruction fetch queue.
//   INST_ADDR_W / INST_W : PC and instruction widths
//   ZERO_WORD            : value driven on the head outputs when idle
//   IFQ_DEPTH / IFQ_AW   : default queue depth and pointer width
//   ifq_entry_t          : one stored {pc, inst} pair
package if_queue_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int IFQ_DEPTH   = 4;
    localparam int IFQ_AW      = 2;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ifq_entry_t;

    localparam int ENTRY_W = $bits(ifq_entry_t);
endpackage

// File: rtl/ifq_storage.sv
// Register array backing the fetch queue.
//   clk          : clock
//   we/waddr/wdata : single synchronous write port
//   raddr/rdata  : asynchronous read port
// Contents are not reset; validity is tracked by the queue pointers.
module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between fetch (pc_reg/ROM) and decode.
//   clk, rst      : clock, synchronous active-high reset
//   if_pc_i/if_inst_i/if_valid_i : fetched word from the fetch stage
//   if_stall_o    : holds pc_reg while the queue is full
//   flush_i       : redirect; drops all queued words and the current input
//   id_ready_i    : decode takes the head this cycle
//   id_valid_o/id_pc_o/id_inst_o : head entry toward decode
//   count_o       : occupancy, 0..DEPTH
// Optional feature macro IFQ_BYPASS_EN: when the queue is empty the incoming
// word is forwarded combinationally to decode (zero-cycle latency).
module if_queue
    import if_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = IFQ_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] if_pc_i,
    input  logic [INST_W-1:0]      if_inst_i,
    input  logic                   if_valid_i,
    output logic                   if_stall_o,
    input  logic                   flush_i,
    input  logic                   id_ready_i,
    output logic                   id_valid_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic [AW:0]            count_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count_q;
    logic          full, empty, byp, byp_take, push, pop;
    ifq_entry_t    head, wr_entry;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    // rst gates the forward path so outputs read idle during reset.
    assign byp = empty && if_valid_i && !flush_i && !rst;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that decode takes immediately is never stored.
    assign byp_take = byp && id_ready_i;
    // Refused when full even if a pop frees a slot this cycle; the stall
    // keeps the PC so the word is offered again.
    assign push     = if_valid_i && !full && !flush_i && !byp_take;
    assign pop      = !empty && id_ready_i && !flush_i;

    assign wr_entry = '{pc: if_pc_i, inst: if_inst_i};

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (ENTRY_W)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        id_valid_o = !empty || byp;
        id_pc_o    = ZERO_WORD;
        id_inst_o  = ZERO_WORD;
        if (!empty) begin
            id_pc_o   = head.pc;
            id_inst_o = head.inst;
        end else if (byp) begin
            id_pc_o   = if_pc_i;
            id_inst_o = if_inst_i;
        end
    end

    assign if_stall_o = full;
    assign count_o    = count_q;
endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, if_valid_i, flush_i, id_ready_i;
    logic [31:0] if_pc_i, if_inst_i;
    logic        if_stall_o, id_valid_o;
    logic [31:0] id_pc_o, id_inst_o;
    logic [2:0]  count_o;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] sb[$];  // expected {pc, inst} in delivery order
    bit          known = 0;

    if_queue dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_valid_i (if_valid_i),
        .if_stall_o (if_stall_o),
        .flush_i    (flush_i),
        .id_ready_i (id_ready_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h34011100 + pc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, update the scoreboard.
    task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                       input logic f, input logic rdy, output logic acc);
        logic byp, was_full;
        rst = r; if_valid_i = v; if_pc_i = pc; if_inst_i = inst_of(pc);
        flush_i = f; id_ready_i = rdy;
        @(negedge clk);
        acc = 1'b0;
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (sb.size() == 0) && v && !f && !r;
`endif
        if (known) begin
            chk("valid", id_valid_o, (sb.size() > 0) || byp);
            chk("count", count_o, sb.size());
            chk("stall", if_stall_o, sb.size() == DEPTH);
            if (sb.size() > 0) begin
                chk("head_pc", id_pc_o, sb[0][63:32]);
                chk("head_inst", id_inst_o, sb[0][31:0]);
            end else if (byp) begin
                chk("byp_pc", id_pc_o, pc);
                chk("byp_inst", id_inst_o, inst_of(pc));
            end else begin
                chk("idle_pc", id_pc_o, 0);
                chk("idle_inst", id_inst_o, 0);
            end
        end
        if (r) begin
            sb.delete();
            known = 1;
        end else if (f) begin
            sb.delete();
        end else if (byp && rdy) begin
            acc = 1'b1;
        end else begin
            was_full = (sb.size() == DEPTH);
            if (sb.size() > 0 && rdy) void'(sb.pop_front());
            if (v && !was_full) begin
                sb.push_back({pc, inst_of(pc)});
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one word until accepted (bounded).
    task automatic feed(input logic [31:0] pc, input logic rdy);
        logic acc;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, pc, 1'b0, rdy, acc);
            if (acc) return;
        end
        chk("feed_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        // Reset for 2 cycles with a valid fetch word present.
        cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        chk("rst_cnt", count_o, 0);
        chk("rst_vld", id_valid_o, 0);
        chk("rst_stall", if_stall_o, 0);

        // Fill with decode stalled, then a 5th word held by the stall.
        feed(32'h0, 1'b0);
        feed(32'h4, 1'b0);
        feed(32'h8, 1'b0);
        feed(32'hC, 1'b0);
        chk("fill_cnt", count_o, 4);
        chk("fill_stall", if_stall_o, 1);
        cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, acc);
        chk("held_acc", acc, 0);
        // Full with pop: refused this cycle, count drops to 3.
        cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, acc);
        chk("fullpop_acc", acc, 0);
        chk("fullpop_cnt", count_o, 3);
        feed(32'h10, 1'b0);
        chk("refill_cnt", count_o, 4);
        drain();

        // Steady streaming, 20 words across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            feed(32'h200 + 32'(i) * 4, 1'b1);
            chk("stream_le1", count_o <= 1, 1);
        end
        drain();

        // Flush with 3 queued words and a valid word at 0x40.
        feed(32'h300, 1'b0);
        feed(32'h304, 1'b0);
        feed(32'h308, 1'b0);
        cyc(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, acc);
        chk("flush_cnt", count_o, 0);
        chk("flush_vld", id_valid_o, 0);
        feed(32'h100, 1'b0);
        drain();

        // Mid-operation reset during a simultaneous push and pop.
        feed(32'h500, 1'b0);
        feed(32'h504, 1'b0);
        cyc(1'b1, 1'b1, 32'h508, 1'b0, 1'b1, acc);
        chk("mrst_cnt", count_o, 0);
        chk("mrst_vld", id_valid_o, 0);
        chk("mrst_stall", if_stall_o, 0);
        feed(32'h600, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
